pipe_sched: RTL and testbench

PIPE_SCHED -- requirements
Module: pipe_sched

---
 rtl/pipe_sched.sv | 122 ++++++++++++
 tb/tb_pipe_sched.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/pipe_sched.sv
// Pipeline stall/flush scheduler: arbitrates load-use, divide and memory hazards
// into a StallBus, redirects on exceptions, and watches for a hung divider.
module pipe_sched #(
  parameter int DIV_TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        div_start,
  input  logic        div_ready,
  input  logic        stallreq_mem,
  input  logic        excp_valid,
  input  logic [31:0] excp_pc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        div_timeout,
  output logic [31:0] stall_cycles
);

  localparam int CW = $clog2(DIV_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  typedef enum logic [1:0] {S_IDLE, S_DIV_WAIT, S_MEM_WAIT, S_FLUSH} state_e;

  state_e          r_state;
  state_e          w_state_next;
  state_e          w_idle_next;
  logic [5:0]      w_idle_stall;
  logic [CW-1:0]   r_div_cnt;
  logic            r_div_timeout;
  logic [31:0]     r_stall_cycles;
  logic            w_div_expired;

  // Request arbitration as seen from IDLE; MEM_WAIT reuses it on release.
  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_idle_stall = STALL_NONE;
    w_idle_next  = S_IDLE;
    if (stallreq_mem) begin
      w_idle_stall = STALL_MEM;
      w_idle_next  = S_MEM_WAIT;
    end else if (div_start && !div_ready) begin
      w_idle_stall = STALL_EX;
      w_idle_next  = S_DIV_WAIT;
    end else if (stallreq_id) begin
      w_idle_stall = STALL_ID;
    end
  end

  assign w_div_expired = (r_state == S_DIV_WAIT) && !div_ready && (r_div_cnt == CNT_LAST);

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (excp_valid) begin
      w_state_next = S_FLUSH;
    end else begin
      case (r_state)
        S_IDLE:     w_state_next = w_idle_next;
        S_DIV_WAIT: begin
          if (div_ready)          w_state_next = stallreq_mem ? S_MEM_WAIT : S_IDLE;
          else if (w_div_expired) w_state_next = S_IDLE;
        end
        S_MEM_WAIT: if (!stallreq_mem) w_state_next = w_idle_next;
        S_FLUSH:    w_state_next = S_IDLE;
        default:    w_state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    stall        = STALL_NONE;
    flush        = 1'b0;
    new_pc       = 32'h0;
    div_timeout  = r_div_timeout & ~rst;
    stall_cycles = rst ? 32'h0 : r_stall_cycles;
    if (rst) begin
      stall = STALL_NONE;
    end else if (excp_valid) begin
      flush  = 1'b1;
      new_pc = excp_pc;
    end else begin
      case (r_state)
        S_IDLE:     stall = w_idle_stall;
        S_DIV_WAIT: begin
          if (stallreq_mem)    stall = STALL_MEM;
          else if (!div_ready) stall = STALL_EX;
        end
        S_MEM_WAIT: stall = stallreq_mem ? STALL_MEM : w_idle_stall;
        S_FLUSH:    stall = STALL_NONE;
        default:    stall = STALL_NONE;
      endcase
    end
  end

  // The wait counter idles at zero outside DIV_WAIT, so each entry starts fresh.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt      <= '0;
      r_div_timeout  <= 1'b0;
      r_stall_cycles <= 32'h0;
    end else begin
      if (r_state == S_DIV_WAIT) r_div_cnt <= r_div_cnt + CNT_ONE;
      else                       r_div_cnt <= '0;
      if (w_div_expired && !excp_valid) r_div_timeout <= 1'b1;
      if (stall != STALL_NONE) r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_pipe_sched.sv
// Directed bench for pipe_sched: stimulus pushes expected outputs per cycle,
// a negedge monitor pops and compares them against the DUT.
module tb_pipe_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stallreq_id = 1'b0;
  logic        div_start = 1'b0;
  logic        div_ready = 1'b0;
  logic        stallreq_mem = 1'b0;
  logic        excp_valid = 1'b0;
  logic [31:0] excp_pc = 32'h0;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        div_timeout;
  logic [31:0] stall_cycles;

  localparam logic [5:0] S0 = 6'b000000;
  localparam logic [5:0] SI = 6'b000111;
  localparam logic [5:0] SE = 6'b001111;
  localparam logic [5:0] SM = 6'b011111;

  typedef struct {
    int          cyc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
    logic        to;
    logic [31:0] sc;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int unsigned m_sc = 0;

  pipe_sched #(.DIV_TIMEOUT(40)) dut (
    .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .div_start(div_start),
    .div_ready(div_ready), .stallreq_mem(stallreq_mem), .excp_valid(excp_valid),
    .excp_pc(excp_pc), .stall(stall), .flush(flush), .new_pc(new_pc),
    .div_timeout(div_timeout), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int c, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, c, act, exp_v);
    end
  endtask

  // One stimulus cycle: drive inputs after the edge and queue the expected outputs.
  task automatic step(input logic r, input logic id, input logic ds, input logic dr,
                      input logic mem, input logic ev, input logic [31:0] pc,
                      input logic [5:0] e_stall, input logic e_flush, input logic [31:0] e_pc,
                      input logic e_to);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; stallreq_id = id; div_start = ds; div_ready = dr;
    stallreq_mem = mem; excp_valid = ev; excp_pc = pc;
    cyc++;
    e.cyc = cyc; e.stall = e_stall; e.flush = e_flush; e.pc = e_pc; e.to = e_to;
    if (r) begin
      e.sc = 32'h0;
      m_sc = 0;
    end else begin
      e.sc = m_sc;
      if (e_stall != S0) m_sc++;
    end
    q.push_back(e);
  endtask

  task automatic quiet(input int n, input logic e_to);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 32'h0, S0, 0, 32'h0, e_to);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("stall", e.cyc, 32'(stall), 32'(e.stall));
      check("flush", e.cyc, 32'(flush), 32'(e.flush));
      check("new_pc", e.cyc, new_pc, e.pc);
      check("div_timeout", e.cyc, 32'(div_timeout), 32'(e.to));
      check("stall_cycles", e.cyc, stall_cycles, e.sc);
    end
  end

  initial begin
    // reset, then idle
    step(1, 1, 1, 0, 1, 1, 32'h1234, S0, 0, 32'h0, 0);
    step(1, 0, 0, 0, 0, 0, 32'h0, S0, 0, 32'h0, 0);
    quiet(1, 0);
    // single load-use stall
    step(0, 1, 0, 0, 0, 0, 32'h0, SI, 0, 32'h0, 0);
    quiet(1, 0);
    // div_start with same-cycle div_ready: no stall, stays IDLE
    step(0, 0, 1, 1, 0, 0, 32'h0, S0, 0, 32'h0, 0);
    quiet(1, 0);
    // divide resolved 10 cycles after start
    step(0, 0, 1, 0, 0, 0, 32'h0, SE, 0, 32'h0, 0);
    for (int i = 0; i < 9; i++) step(0, 0, 0, 0, 0, 0, 32'h0, SE, 0, 32'h0, 0);
    step(0, 0, 0, 1, 0, 0, 32'h0, S0, 0, 32'h0, 0);
    quiet(1, 0);
    // MEM and ID together: MEM wins
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 1, 0, 32'h0, SM, 0, 32'h0, 0);
    quiet(1, 0);
    // exception abandons a divide; FLUSH ignores requests for one cycle
    step(0, 0, 1, 0, 0, 0, 32'h0, SE, 0, 32'h0, 0);
    step(0, 0, 0, 0, 0, 0, 32'h0, SE, 0, 32'h0, 0);
    step(0, 0, 0, 0, 0, 0, 32'h0, SE, 0, 32'h0, 0);
    step(0, 0, 0, 0, 0, 1, 32'hBFC00380, S0, 1, 32'hBFC00380, 0);
    step(0, 1, 0, 0, 1, 0, 32'h0, S0, 0, 32'h0, 0);
    step(0, 1, 0, 0, 0, 0, 32'h0, SI, 0, 32'h0, 0);
    quiet(1, 0);
    // back-to-back exceptions re-flush
    step(0, 0, 0, 0, 0, 1, 32'h00000100, S0, 1, 32'h00000100, 0);
    step(0, 0, 0, 0, 0, 1, 32'h00000200, S0, 1, 32'h00000200, 0);
    step(0, 0, 1, 0, 1, 0, 32'h0, S0, 0, 32'h0, 0);
    quiet(1, 0);
    // exception outranks every request
    step(0, 1, 1, 0, 1, 1, 32'h8000_0180, S0, 1, 32'h8000_0180, 0);
    step(0, 0, 0, 0, 0, 0, 32'h0, S0, 0, 32'h0, 0);
    // MEM release falls back to IDLE arbitration that cycle
    step(0, 0, 0, 0, 1, 0, 32'h0, SM, 0, 32'h0, 0);
    step(0, 1, 0, 0, 0, 0, 32'h0, SI, 0, 32'h0, 0);
    quiet(1, 0);
    // divider timeout after 40 waiting cycles; flag is sticky
    step(0, 0, 1, 0, 0, 0, 32'h0, SE, 0, 32'h0, 0);
    for (int i = 0; i < 40; i++) step(0, 0, 0, 0, 0, 0, 32'h0, SE, 0, 32'h0, 0);
    step(0, 0, 0, 0, 0, 0, 32'h0, S0, 0, 32'h0, 1);
    step(0, 0, 0, 1, 0, 0, 32'h0, S0, 0, 32'h0, 1);
    step(0, 1, 0, 0, 0, 0, 32'h0, SI, 0, 32'h0, 1);
    // reset clears everything, then reset in the middle of MEM_WAIT
    step(1, 0, 0, 0, 0, 0, 32'h0, S0, 0, 32'h0, 0);
    quiet(1, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 0, 32'h0, SM, 0, 32'h0, 0);
    step(1, 0, 0, 0, 1, 0, 32'h0, S0, 0, 32'h0, 0);
    step(0, 0, 0, 0, 0, 0, 32'h0, S0, 0, 32'h0, 0);
    step(0, 1, 0, 0, 0, 0, 32'h0, SI, 0, 32'h0, 0);
    quiet(1, 0);

    for (int i = 0; i < 4 && q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    check("queue_drain", cyc, 32'(q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
